// File: rtl/wfq_egress_reader.sv
// Paced read-request issuer for a WFQ scheduler: captures dequeued words after a fixed latency
// into a skid FIFO, streams them downstream and keeps per-flow pop statistics.
module wfq_egress_reader #(
    parameter int RD_LATENCY = 7,
    parameter int NUM_FLOWS  = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int ISSUE_GAP  = 2,
    localparam int SEL_W     = (NUM_FLOWS > 1) ? $clog2(NUM_FLOWS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_enable,
    input  logic             in_wfq_buffer_empty,
    input  logic [63:0]      in_wfq_data,
    output logic             out_wfq_rd_req,
    input  logic             in_m_ready,
    output logic             out_m_valid,
    output logic [63:0]      out_m_data,
    input  logic [SEL_W-1:0] in_stat_sel,
    output logic [31:0]      out_stat_count,
    output logic [31:0]      out_stat_other,
    output logic             out_fifo_overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int GAP_W = (ISSUE_GAP > 0) ? $clog2(ISSUE_GAP + 1) : 1;

    // Downstream handshake: a word transfers on a rising edge where out_m_valid and in_m_ready
    // are both 1; out_m_valid never depends on in_m_ready.

    logic                  rd_req_q, rd_req_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic [CNT_W-1:0]      outstanding_q, outstanding_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [RD_LATENCY-1:0] lat_sr_q, lat_sr_d;
    logic                  overflow_q, overflow_d;
    logic [31:0]           flow_cnt_q [NUM_FLOWS];
    logic [31:0]           flow_cnt_d [NUM_FLOWS];
    logic [31:0]           other_cnt_q, other_cnt_d;
    logic [63:0]           mem_q [FIFO_DEPTH];

    logic [CNT_W:0]        committed;
    logic                  issue;
    logic                  capture;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  pop;
    logic                  push;
    logic [63:0]           head;
    logic [12:0]           pop_flow;
    logic                  pop_in_range;

    // FIFO slots already spoken for include reads still in flight, so a capture can never
    // find the FIFO full while the issue rule is respected.
    assign committed  = {1'b0, count_q} + {1'b0, outstanding_q};
    assign issue      = in_enable && !in_wfq_buffer_empty && (gap_q == '0)
                        && (committed < (CNT_W + 1)'(FIFO_DEPTH));
    assign capture    = lat_sr_q[RD_LATENCY-1];
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop        = !fifo_empty && in_m_ready;
    assign push       = capture && (!fifo_full || pop);
    assign head       = mem_q[rd_ptr_q];
    assign pop_flow   = head[12:0];
    assign pop_in_range = (pop_flow < 13'(NUM_FLOWS));

    always_comb begin
        rd_req_d      = issue;
        gap_d         = gap_q;
        outstanding_d = outstanding_q;
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        overflow_d    = overflow_q;
        lat_sr_d      = (lat_sr_q << 1) | RD_LATENCY'(rd_req_q);

        if (issue) begin
            gap_d = GAP_W'(ISSUE_GAP);
        end else if (gap_q != '0) begin
            gap_d = gap_q - 1'b1;
        end

        if (issue && !capture) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (!issue && capture) begin
            outstanding_d = outstanding_q - 1'b1;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end

        if (capture && !push) begin
            overflow_d = 1'b1;
        end
    end

    // Statistics follow what actually left the block, so they count on pop, not on capture.
    always_comb begin
        flow_cnt_d  = flow_cnt_q;
        other_cnt_d = other_cnt_q;
        if (pop) begin
            if (pop_in_range) begin
                for (int f = 0; f < NUM_FLOWS; f++) begin
                    if (pop_flow[SEL_W-1:0] == SEL_W'(f) && flow_cnt_q[f] != 32'hFFFF_FFFF) begin
                        flow_cnt_d[f] = flow_cnt_q[f] + 32'd1;
                    end
                end
            end else if (other_cnt_q != 32'hFFFF_FFFF) begin
                other_cnt_d = other_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_req_q      <= 1'b0;
            gap_q         <= '0;
            outstanding_q <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            lat_sr_q      <= '0;
            overflow_q    <= 1'b0;
            other_cnt_q   <= '0;
            for (int f = 0; f < NUM_FLOWS; f++) begin
                flow_cnt_q[f] <= '0;
            end
        end else begin
            rd_req_q      <= rd_req_d;
            gap_q         <= gap_d;
            outstanding_q <= outstanding_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            lat_sr_q      <= lat_sr_d;
            overflow_q    <= overflow_d;
            other_cnt_q   <= other_cnt_d;
            for (int f = 0; f < NUM_FLOWS; f++) begin
                flow_cnt_q[f] <= flow_cnt_d[f];
            end
        end
    end

    // Storage needs no reset: the occupancy count gates everything read out of it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_wfq_data;
        end
    end

    always_comb begin
        out_stat_count = '0;
        for (int f = 0; f < NUM_FLOWS; f++) begin
            if (in_stat_sel == SEL_W'(f)) begin
                out_stat_count = flow_cnt_q[f];
            end
        end
    end

    assign out_wfq_rd_req    = rd_req_q;
    assign out_m_valid       = !fifo_empty;
    assign out_m_data        = fifo_empty ? 64'd0 : head;
    assign out_stat_other    = other_cnt_q;
    assign out_fifo_overflow = overflow_q;

endmodule
